// File: rtl/seg595_scan_driver.sv
// seg595_scan_driver: hex 7-segment scan driver feeding a 74HC595 chain.
// Define SEG595_LZB_EN to enable leading-zero blanking.
module seg595_scan_driver #(
    parameter int DIGITS = 8,
    parameter int CLK_DIV = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    localparam int W = 8 + DIGITS,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    output logic                lock595,
    output logic                out595,
    output logic                clk595,
    output logic                frame_done,
    output logic [IW-1:0]       digit_idx
);

    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam int BW = $clog2(W + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HI = PW'(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t              state;
    logic [PW-1:0]       ph;
    logic [PW-1:0]       ph_nx;
    logic [BW-1:0]       bit_cnt;
    logic [W-1:0]        shreg;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;

    logic [4*DIGITS-1:0] src_data;
    logic [DIGITS-1:0]   src_dp;
    logic [DIGITS-1:0]   src_blank;
    logic [DIGITS-1:0]   lz;
    logic [3:0]          nib;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   sel;
    logic [W-1:0]        word;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign ph_nx = ph + PW'(1);

    // Digit 0 builds straight from the inputs it is about to shadow.
    always_comb begin
        src_data  = (digit_idx == '0) ? data : sh_data;
        src_dp    = (digit_idx == '0) ? dp : sh_dp;
        src_blank = (digit_idx == '0) ? blank : sh_blank;
        lz = '0;
`ifdef SEG595_LZB_EN
        begin : lzb
            logic run;
            run = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                run = run && (src_data[4*i +: 4] == 4'h0);
                lz[i] = run;
            end
        end
`endif
        nib = src_data[4*digit_idx +: 4];
        seg = {src_dp[digit_idx], hex7(nib)};
        if (lz[digit_idx]) seg[6:0] = '0;
        if (src_blank[digit_idx]) seg = '0;
        if (SEG_ACTIVE_LOW) seg = ~seg;
        sel = DIGITS'(1) << digit_idx;
        if (SEL_ACTIVE_LOW) sel = ~sel;
        word = {seg, sel};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lock595    <= 1'b0;
            out595     <= 1'b0;
            clk595     <= 1'b0;
            frame_done <= 1'b0;
            digit_idx  <= '0;
            ph         <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    lock595 <= 1'b0;
                    out595  <= 1'b0;
                    clk595  <= 1'b0;
                    if (enable) state <= LOAD;
                end
                LOAD: begin
                    if (digit_idx == '0) begin
                        sh_data  <= data;
                        sh_dp    <= dp;
                        sh_blank <= blank;
                    end
                    shreg   <= word;
                    out595  <= word[W-1];
                    clk595  <= 1'b0;
                    ph      <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (ph == PH_LAST) begin
                        ph     <= '0;
                        clk595 <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            lock595 <= 1'b1;
                            state   <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {shreg[W-2:0], 1'b0};
                            out595  <= shreg[W-2];
                        end
                    end else begin
                        ph     <= ph_nx;
                        clk595 <= (ph_nx >= PH_HI);
                    end
                end
                LATCH: begin
                    if (ph == PH_LAST) begin
                        ph         <= '0;
                        lock595    <= 1'b0;
                        frame_done <= (digit_idx == IDX_LAST);
                        digit_idx  <= (digit_idx == IDX_LAST) ? '0
                                      : digit_idx + 1'b1;
                        if (enable) begin
                            state <= LOAD;
                        end else begin
                            state  <= IDLE;
                            out595 <= 1'b0;
                        end
                    end else begin
                        ph      <= ph_nx;
                        lock595 <= (ph_nx < PH_HI);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
